// File: rtl/paralelo_serial_com_pkg.sv
// Physical-layer definitions shared by the lane serializer and the receive-side aligner.
package paralelo_serial_com_pkg;

  localparam logic [7:0] COM_SYMBOL     = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;

  typedef enum logic {
    INIT   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/paralelo_serial_com_bit_cnt.sv
// Free-running 3-bit bit-position counter; terminal count marks the last bit of a byte.
module paralelo_serial_com_bit_cnt (
  input  logic clk,
  input  logic reset,
  output logic tc_out
);

  logic [2:0] cnt_q, cnt_d;

  // Natural 3-bit wrap gives the 7 -> 0 return at the byte boundary.
  always_comb begin
    cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 3'd0;
    else       cnt_q <= cnt_d;
  end

  assign tc_out = (cnt_q == 3'd7);

endmodule

// File: rtl/paralelo_serial_com.sv
// Lane serializer: COM preamble after reset, then MSB-first bytes with COM idle fill.
module paralelo_serial_com
  import paralelo_serial_com_pkg::*;
#(
  parameter int SYNC_COUNT = SYNC_COUNT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             sync_done_out,
  output logic [CNT_W-1:0] tx_count_out
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  state_e           state_q, state_d;
  logic [3:0]       com_cnt_q, com_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sync_done_q, sync_done_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic             boundary;
  logic             xfer;

  paralelo_serial_com_bit_cnt u_bit_cnt (
    .clk    (clk_32f),
    .reset  (reset),
    .tc_out (boundary)
  );

  // The last preamble boundary already accepts data, so the stream has no gap after sync.
  assign ready_out = boundary &
                     ((state_q == ACTIVE) || ((state_q == INIT) && (com_cnt_q == SYNC_LAST)));
  assign xfer      = valid_in & ready_out;

  always_comb begin
    state_d     = state_q;
    com_cnt_d   = com_cnt_q;
    sync_done_d = sync_done_q;
    tx_count_d  = tx_count_q + {{(CNT_W-1){1'b0}}, xfer};
    shreg_d     = {shreg_q[6:0], 1'b0};

    if (boundary) begin
      shreg_d = xfer ? data_in : COM_SYMBOL;
      if (state_q == INIT) begin
        com_cnt_d = com_cnt_q + 4'd1;
        if (com_cnt_q == SYNC_LAST) begin
          state_d     = ACTIVE;
          sync_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      com_cnt_q   <= 4'd0;
      shreg_q     <= COM_SYMBOL;
      sync_done_q <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      com_cnt_q   <= com_cnt_d;
      shreg_q     <= shreg_d;
      sync_done_q <= sync_done_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign data_out      = shreg_q[7];
  assign sync_done_out = sync_done_q;
  assign tx_count_out  = tx_count_q;

endmodule

// File: doc/paralelo_serial_com.md
Name: paralelo_serial_com

Overview:
Transmit-side lane serializer that produces the serial bitstream consumed by one receive lane (serial-to-parallel stage plus 8b-to-32b demux).
- After reset it emits SYNC_COUNT COM symbols (8'hBC) so the receiver can align.
- It then accepts bytes via a valid/ready handshake and shifts them out MSB first, one bit per clk_32f.
- It inserts COM whenever no valid byte is offered at a byte boundary.
- One instance per lane, clocked only by clk_32f.

Parameters:
SYNC_COUNT, 4, number of complete COM symbols sent after reset before data is accepted (legal range 1..15)
CNT_W, 16, width of the transmitted-data-byte counter

Ports:
clk_32f  input  1  bit clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  8  byte to transmit
valid_in  input  1  data_in holds a byte to send
ready_out  output  1  byte boundary; byte transferred on edge where valid_in & ready_out
data_out  output  1  serial bit, MSB first, driven directly from shreg[7]
sync_done_out  output  1  high once the SYNC_COUNT COM preamble has finished
tx_count_out  output  CNT_W  count of data bytes accepted; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, while reset=1):
  - shreg=8'hBC, bit_cnt=0, com_cnt=0, state=INIT.
  - sync_done_out=0, tx_count_out=0.
  - data_out=1 (MSB of COM); ready_out=0.
- Shifting: each edge with bit_cnt<7 does bit_cnt+1 and shreg={shreg[6:0],1'b0}. A byte occupies data_out for exactly 8 cycles.
- Byte boundary is the edge where bit_cnt==7:
  - bit_cnt returns to 0.
  - shreg loads the next byte: data_in if (valid_in & ready_out), else 8'hBC.
- ready_out is combinational: (bit_cnt==7) & (state==ACTIVE | (state==INIT & com_cnt==SYNC_COUNT-1)). It does not depend on valid_in.
- Latency: a byte accepted at edge E drives its MSB on data_out in the cycle after E, and its LSB 7 cycles later.
- FSM:
  - INIT: each boundary increments com_cnt. At the boundary where com_cnt==SYNC_COUNT-1, go to ACTIVE and set sync_done_out=1 on the same edge. The byte loaded on that edge may already be data.
  - ACTIVE: stay until reset. There is no return to INIT.
- tx_count_out increments by 1 on each accepted transfer, wrapping from all-ones to 0.
- Idle insertion: valid_in=0 at a boundary in ACTIVE sends COM. tx_count_out is unchanged.
- A data byte equal to 8'hBC is accepted and sent unmodified and counted. The receiver will treat it as idle; the upstream stage must not send it.
- valid_in/data_in outside ready_out cycles are ignored. Holding data stable is not required.
- Reset mid-byte aborts the current byte immediately. Preamble restarts from com_cnt=0.
- Back-to-back transfers (valid_in held high) give a continuous stream with no gap bits.

Decomposition:
- Shared package/include (phy_defs):
  - COM_SYMBOL=8'hBC
  - state encodings INIT=1'b0, ACTIVE=1'b1
  - SYNC_COUNT default
- Used also by the receive-side aligner.
- No sub-module required; a small bit counter (bit_cnt_8, 3-bit, wrap at 7, terminal-count output) is a natural optional sub-module.

Test Plan:
1. Reset then valid_in=0 for 64 cycles -> data_out pattern 10111100 repeated 8 times. ready_out first high at cycle 31 (SYNC_COUNT=4). sync_done_out rises at edge 32. tx_count_out=0.
2. valid_in=1 with data_in=8'hA5 from cycle 0 -> first accepted at edge 32. Bits 1,0,1,0,0,1,0,1 on cycles 32..39. tx_count_out=1.
3. Stream 8'h01,8'h02,8'h03 back-to-back after sync -> 24 contiguous bits 00000001 00000010 00000011, no COM between. tx_count_out=3.
4. Offer 8'h5A only on a non-boundary cycle, drop at boundary -> COM transmitted, tx_count_out unchanged.
5. Assert reset for 1 cycle during bit 4 of a data byte -> data_out=1 immediately. Full 4-COM preamble repeats, sync_done_out=0 until the new preamble ends.
6. Preload counter near wrap with CNT_W=4: send 17 bytes -> tx_count_out=1. Also send data 8'hBC -> transmitted as 10111100 and counted.
